free_list_reclaim_ctrl: RTL
===========================

# free_list_reclaim_ctrl

Sequencer between the ROB/flush logic and the physical-register free list. On a pipeline flush it captures the squashed instructions' physical destination registers (up to 16) and drains them into the free list's flush-recovery port at a bounded rate. While it drains, it stalls rename allocation. It also forwards commit-time frees with a one-cycle register stage, so the free list never sees more than DRAIN_W+1 returns per cycle.

## Interface
- PHYS_W, default 6: physical register index width.
- DEPTH, default 16: maximum registers captured per flush.
- DRAIN_W, default 4: maximum registers returned per drain beat. Legal range is 1..DEPTH, with DRAIN_W+1 ≤ 7 (the free list's per-cycle return limit).
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- flush_req, input, 1: single-cycle flush request.
- flush_count, input, 5: number of valid entries in flush_phys. Values above DEPTH are clamped to DEPTH.
- flush_phys, input, [DEPTH] x PHYS_W: squashed physical registers, compacted from index 0.
- commit_free_en, input, 1: commit frees the stale mapping.
- commit_free_phys, input, PHYS_W: register freed at commit.
- fl_free_en, output, 1: to the free list's normal free port.
- fl_free_phys, output, PHYS_W: register on the normal free port.
- fl_flush_free_count, output, 5: entries valid this cycle on the flush port, range 0..DRAIN_W.
- fl_flush_free_phys, output, [DEPTH] x PHYS_W: slots 0..DRAIN_W-1 carry data; all other slots are 0.
- rename_stall, output, 1: rename must not allocate.
- busy, output, 1: state is not IDLE.
- flush_done, output, 1: one-cycle pulse when recovery completes.
- flush_overrun, output, 1: one-cycle pulse when a flush_req was dropped.
- pending, output, 5: registers still to be drained.

## Operation
- State machine with states IDLE, DRAIN and DONE. Reset enters IDLE.
- IDLE, flush_req=1:
  - Latch min(flush_count, DEPTH) into remaining.
  - Copy flush_phys into the buffer and set rd_ptr=0.
  - Next state is DRAIN if remaining>0, otherwise DONE.
- DRAIN, each cycle:
  - beat = min(remaining, DRAIN_W).
  - fl_flush_free_phys[i] = buf[rd_ptr+i] for i<beat, and 0 for all other slots.
  - fl_flush_free_count = beat.
  - On the clock edge: rd_ptr += beat and remaining -= beat. If remaining==beat, go to DONE.
- DONE: assert flush_done for one cycle, then return to IDLE.
- flush_req outside IDLE is dropped. The buffer, remaining count and state are unchanged, and flush_overrun pulses in the following cycle.
- Commit path: fl_free_en and fl_free_phys are registered copies of commit_free_en and commit_free_phys, with one cycle of latency. This path runs in every state and is independent of the FSM.
- Output derivations:
  - rename_stall = flush_req | (state != IDLE). This is the only combinational input-to-output path.
  - busy = (state != IDLE).
  - pending = remaining.
  - In IDLE and DONE, fl_flush_free_count=0 and all fl_flush_free_phys slots are 0.
- Buffer width arithmetic: rd_ptr is 5 bits and never exceeds DEPTH; remaining is 5 bits and never underflows.
- Physical register 0 in flush_phys is returned as-is. Filtering it is upstream's responsibility.

## Timing
- Reset values: state IDLE, remaining=0, rd_ptr=0, fl_free_en=0, fl_free_phys=0, fl_flush_free_count=0, all fl_flush_free_phys slots 0, busy=0, flush_done=0, flush_overrun=0, pending=0. rename_stall is 0 while flush_req is low.
- Reset asserted mid-DRAIN: the block returns to IDLE immediately and undrained entries are discarded. The free list is reset by the same rst, so nothing leaks.
- flush_req at cycle T with N>0 entries:
  - Drain beats occupy cycles T+1 .. T+ceil(N/DRAIN_W).
  - flush_done pulses in the cycle after the last beat.
  - rename_stall is high from T through the DONE cycle and low in the first IDLE cycle after DONE.
- flush_req at T with N=0: DONE at T+1, IDLE at T+2.
- A commit free and a drain beat in the same cycle are both driven. The free list sees 1+beat returns, which is at most 5 with defaults.
- A flush_req arriving in the same cycle as DONE is dropped, with an overrun pulse. A flush_req in the first IDLE cycle after DONE is accepted.

## Test plan
- Reset, then idle: all outputs 0 and rename_stall=0. A commit free of phys 9 at T gives fl_free_en=1 and fl_free_phys=9 at T+1 only.
- Flush with N=16, DRAIN_W=4, entries 17..32:
  - Beats at T+1..T+4 carry {17-20}, {21-24}, {25-28}, {29-32}, each with count=4.
  - flush_done at T+5; rename_stall high T..T+5 and low at T+6.
- Flush with N=6: beats {a0-a3} with count=4, then {a4,a5} with count=2 and slots 2..3 zero. pending goes 6→2→0.
- Flush with N=0: no beats, flush_done at T+1. Flush with N=20: clamped to 16, giving 4 beats.
- Second flush_req during DRAIN: ignored, flush_overrun pulses, and the original beat sequence is unchanged. Commit frees issued during DRAIN appear with one-cycle latency alongside the beats.
- Async rst asserted between beats 2 and 3 of a 16-entry drain: outputs go to reset values without waiting for a clock edge, and no further beats occur after rst is released.

Source files
------------

// File: rtl/free_list_reclaim_ctrl_if.sv
// Bundle between the ROB/flush logic, the reclaim controller and the
// physical-register free list.
//
// slave  : the reclaim controller (consumes flush/commit, drives free list)
// master : the environment (drives flush/commit, observes free-list side)
//
// Signals:
//   flush_req, flush_count, flush_phys      flush capture from ROB
//   commit_free_en, commit_free_phys        commit-time stale-mapping free
//   fl_free_en, fl_free_phys                free list normal free port
//   fl_flush_free_count, fl_flush_free_phys free list flush-recovery port
//   rename_stall, busy, flush_done,
//   flush_overrun, pending                  status
interface free_list_reclaim_ctrl_if #(
  parameter int PHYS_W = 6,
  parameter int DEPTH  = 16
);
  logic                          flush_req;
  logic [4:0]                    flush_count;
  logic [DEPTH-1:0][PHYS_W-1:0]  flush_phys;
  logic                          commit_free_en;
  logic [PHYS_W-1:0]             commit_free_phys;
  logic                          fl_free_en;
  logic [PHYS_W-1:0]             fl_free_phys;
  logic [4:0]                    fl_flush_free_count;
  logic [DEPTH-1:0][PHYS_W-1:0]  fl_flush_free_phys;
  logic                          rename_stall;
  logic                          busy;
  logic                          flush_done;
  logic                          flush_overrun;
  logic [4:0]                    pending;

  modport master (
    output flush_req, flush_count, flush_phys, commit_free_en, commit_free_phys,
    input  fl_free_en, fl_free_phys, fl_flush_free_count, fl_flush_free_phys,
    input  rename_stall, busy, flush_done, flush_overrun, pending
  );

  modport slave (
    input  flush_req, flush_count, flush_phys, commit_free_en, commit_free_phys,
    output fl_free_en, fl_free_phys, fl_flush_free_count, fl_flush_free_phys,
    output rename_stall, busy, flush_done, flush_overrun, pending
  );
endinterface

// File: rtl/free_list_reclaim_ctrl.sv
// Flush reclaim sequencer for the physical-register free list.
// On flush_req it captures up to DEPTH squashed destination registers and
// drains them into the free list's flush-recovery port, at most DRAIN_W per
// cycle, stalling rename until recovery is complete. Commit-time frees are
// forwarded through a one-cycle register stage in every state.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : free_list_reclaim_ctrl_if.slave (flush capture, commit free,
//          free-list ports and status)
//
// state | meaning
// IDLE  | waiting for flush_req; commit forwarding only
// DRAIN | returning min(remaining, DRAIN_W) captured registers per cycle
// DONE  | one-cycle flush_done pulse, rename still stalled
module free_list_reclaim_ctrl #(
  parameter int PHYS_W  = 6,
  parameter int DEPTH   = 16,
  parameter int DRAIN_W = 4
) (
  input  logic clk,
  input  logic rst,
  free_list_reclaim_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  DEPTH_C = 5'(DEPTH);
  localparam logic [4:0]  DRAIN_C = 5'(DRAIN_W);

  state_t                       state;
  logic [4:0]                   remaining;
  logic [4:0]                   rd_ptr;
  logic [DEPTH-1:0][PHYS_W-1:0] buf_q;
  logic                         overrun_q;
  logic                         free_en_q;
  logic [PHYS_W-1:0]            free_phys_q;

  logic [4:0]                   flush_len;
  logic [4:0]                   beat;
  logic [4:0]                   slot;
  logic [DEPTH-1:0][PHYS_W-1:0] drain_phys;

  always_comb begin
    flush_len = (bus.flush_count > DEPTH_C) ? DEPTH_C : bus.flush_count;
    beat      = '0;
    if (state == DRAIN) begin
      beat = (remaining > DRAIN_C) ? DRAIN_C : remaining;
    end
  end

  // Slots at or beyond the beat size stay zero so the free list can ignore
  // them regardless of how it decodes the count.
  always_comb begin
    drain_phys = '0;
    slot       = '0;
    for (int i = 0; i < DRAIN_W; i++) begin
      slot = rd_ptr + 5'(i);
      if ((5'(i) < beat) && (slot < DEPTH_C)) begin
        drain_phys[i] = buf_q[slot[IDX_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      remaining   <= '0;
      rd_ptr      <= '0;
      buf_q       <= '0;
      overrun_q   <= 1'b0;
      free_en_q   <= 1'b0;
      free_phys_q <= '0;
    end else begin
      free_en_q   <= bus.commit_free_en;
      free_phys_q <= bus.commit_free_phys;
      // A request is only accepted in IDLE; anywhere else it is reported.
      overrun_q   <= bus.flush_req && (state != IDLE);

      case (state)
        IDLE: begin
          if (bus.flush_req) begin
            remaining <= flush_len;
            buf_q     <= bus.flush_phys;
            rd_ptr    <= '0;
            state     <= (flush_len != '0) ? DRAIN : DONE;
          end
        end
        DRAIN: begin
          rd_ptr    <= rd_ptr + beat;
          remaining <= remaining - beat;
          if (remaining == beat) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.fl_free_en          = free_en_q;
  assign bus.fl_free_phys        = free_phys_q;
  assign bus.fl_flush_free_count = beat;
  assign bus.fl_flush_free_phys  = drain_phys;
  assign bus.busy                = (state != IDLE);
  assign bus.rename_stall        = bus.flush_req | (state != IDLE);
  assign bus.flush_done          = (state == DONE);
  assign bus.flush_overrun       = overrun_q;
  assign bus.pending             = remaining;

endmodule
